// File: rtl/ms_mine_field_gen.sv
// Minesweeper mine-field generator: a free-running 16-bit LFSR supplies cell indices,
// and an IDLE/GEN/DONE FSM places MINES distinct mines into a 64-bit occupancy vector.
module ms_mine_field_gen #(
   parameter int          MINES = 10,
   parameter logic [15:0] SEED  = 16'hACE1
) (
   input  logic        clk,
   input  logic        n_reset,
   input  logic        enable,
   input  logic        start,
   output logic [5:0]  rand_idx,
   output logic [63:0] mine,
   output logic        gen_done
);

   typedef enum logic [1:0] {
      IDLE,
      GEN,
      DONE
   } state_t;

   localparam logic [6:0] MINES_C = 7'(MINES);

   logic [15:0] lfsr_q, lfsr_d;
   state_t      state_q, state_d;
   logic [63:0] mine_q, mine_d;
   logic [6:0]  count_q, count_d;
   logic        gen_done_q, gen_done_d;
   logic [5:0]  idx;

   assign idx = lfsr_q[5:0];

   // Fibonacci LFSR, x^16+x^14+x^13+x^11+1, independent of the FSM
   always_comb begin
      lfsr_d = lfsr_q;
      if (enable) begin
         lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
      end
   end

   always_comb begin
      state_d    = state_q;
      mine_d     = mine_q;
      count_d    = count_q;
      gen_done_d = gen_done_q;
      if (start) begin
         state_d    = GEN;
         mine_d     = '0;
         count_d    = '0;
         gen_done_d = 1'b0;
      end else begin
         case (state_q)
            GEN: begin
               // A collision leaves everything unchanged; the next index is tried next cycle
               if (enable && !mine_q[idx]) begin
                  mine_d[idx] = 1'b1;
                  count_d     = count_q + 7'd1;
                  if (count_q + 7'd1 == MINES_C) begin
                     gen_done_d = 1'b1;
                     state_d    = DONE;
                  end
               end
            end
            default: begin
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         lfsr_q     <= SEED;
         state_q    <= IDLE;
         mine_q     <= '0;
         count_q    <= '0;
         gen_done_q <= 1'b0;
      end else begin
         lfsr_q     <= lfsr_d;
         state_q    <= state_d;
         mine_q     <= mine_d;
         count_q    <= count_d;
         gen_done_q <= gen_done_d;
      end
   end

   assign rand_idx = lfsr_q[5:0];
   assign mine     = mine_q;
   assign gen_done = gen_done_q;

endmodule

// File: tb/tb_ms_mine_field_gen.sv
// Directed testbench for ms_mine_field_gen with default MINES=10 and SEED=16'hACE1.
module tb_ms_mine_field_gen;

   logic        clk;
   logic        n_reset;
   logic        enable;
   logic        start;
   logic [5:0]  rand_idx;
   logic [63:0] mine;
   logic        gen_done;

   int n_checks;
   int n_fails;

   // Behavioural reference of the generator used for checks where hand values are impractical
   logic [15:0] m_lfsr;
   logic [63:0] m_mine;
   logic [6:0]  m_count;
   logic        m_done;
   logic        m_gen;

   ms_mine_field_gen dut (
      .clk      (clk),
      .n_reset  (n_reset),
      .enable   (enable),
      .start    (start),
      .rand_idx (rand_idx),
      .mine     (mine),
      .gen_done (gen_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         m_lfsr  <= 16'hACE1;
         m_mine  <= '0;
         m_count <= '0;
         m_done  <= 1'b0;
         m_gen   <= 1'b0;
      end else begin
         if (enable) m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
         if (start) begin
            m_mine  <= '0;
            m_count <= '0;
            m_done  <= 1'b0;
            m_gen   <= 1'b1;
         end else if (m_gen && enable && !m_mine[m_lfsr[5:0]]) begin
            m_mine[m_lfsr[5:0]] <= 1'b1;
            m_count             <= m_count + 7'd1;
            if (m_count + 7'd1 == 7'd10) begin
               m_done <= 1'b1;
               m_gen  <= 1'b0;
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input logic en);
      n_reset = 1'b0;
      start   = 1'b0;
      enable  = en;
      tick();
      tick();
      n_reset = 1'b1;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic run_to_done(input string name);
      int cyc;
      cyc = 0;
      while (gen_done !== 1'b1 && cyc < 2000) begin
         tick();
         cyc++;
      end
      n_checks++;
      if (gen_done !== 1'b1) begin
         n_fails++;
         $display("[TB] FAIL %s_timeout: gen_done=%b after %0d cycles, required 1", name, gen_done, cyc);
      end
      n_checks++;
      if ($countones(mine) != 10) begin
         n_fails++;
         $display("[TB] FAIL %s_popcount: got %0d mines, required 10", name, $countones(mine));
      end
      n_checks++;
      if (mine !== m_mine) begin
         n_fails++;
         $display("[TB] FAIL %s_field: got %h, required %h", name, mine, m_mine);
      end
   endtask

   task automatic test_reset();
      n_reset = 1'b0;
      start   = 1'b0;
      enable  = 1'b1;
      tick();
      tick();
      tick();
      n_checks++;
      if (mine !== 64'h0) begin
         n_fails++;
         $display("[TB] FAIL reset_mine: got %h, required 0", mine);
      end
      n_checks++;
      if (gen_done !== 1'b0) begin
         n_fails++;
         $display("[TB] FAIL reset_gen_done: got %b, required 0", gen_done);
      end
      n_checks++;
      if (rand_idx !== 6'h21) begin
         n_fails++;
         $display("[TB] FAIL reset_rand: got %h, required 21", rand_idx);
      end
      n_reset = 1'b1;
      tick();
      n_checks++;
      if (rand_idx !== 6'h03) begin
         n_fails++;
         $display("[TB] FAIL lfsr_step1: got %h, required 03", rand_idx);
      end
      tick();
      n_checks++;
      if (rand_idx !== 6'h07) begin
         n_fails++;
         $display("[TB] FAIL lfsr_step2: got %h, required 07", rand_idx);
      end
      n_checks++;
      if (gen_done !== 1'b0 || mine !== 64'h0) begin
         n_fails++;
         $display("[TB] FAIL idle_no_gen: mine=%h gen_done=%b, required 0/0", mine, gen_done);
      end
   endtask

   task automatic test_first_placements();
      do_reset(1'b0);
      pulse_start();
      n_checks++;
      if (mine !== 64'h0 || rand_idx !== 6'h21) begin
         n_fails++;
         $display("[TB] FAIL start_clear: mine=%h rand=%h, required 0/21", mine, rand_idx);
      end
      enable = 1'b1;
      tick();
      n_checks++;
      if (mine !== 64'h0000_0002_0000_0000) begin
         n_fails++;
         $display("[TB] FAIL first_mine: got %h, required 0000000200000000", mine);
      end
      tick();
      tick();
      n_checks++;
      if (mine !== 64'h0000_0002_0000_0088) begin
         n_fails++;
         $display("[TB] FAIL three_mines: got %h, required 0000000200000088", mine);
      end
      n_checks++;
      if (gen_done !== 1'b0) begin
         n_fails++;
         $display("[TB] FAIL three_mines_done: got %b, required 0", gen_done);
      end
   endtask

   task automatic test_free_run();
      logic [63:0] field;
      int          changed;
      run_to_done("free_run");
      n_checks++;
      if ((mine & 64'h0000_0002_0000_0088) !== 64'h0000_0002_0000_0088) begin
         n_fails++;
         $display("[TB] FAIL free_run_early_bits: got %h, required bits 33,7,3 set", mine);
      end
      field   = m_mine;
      changed = 0;
      for (int i = 0; i < 100; i++) begin
         tick();
         if (mine !== field || gen_done !== 1'b1) changed++;
      end
      n_checks++;
      if (changed != 0) begin
         n_fails++;
         $display("[TB] FAIL done_frozen: %0d cycles differed, required 0 (mine=%h)", changed, mine);
      end
      n_checks++;
      if (rand_idx !== m_lfsr[5:0]) begin
         n_fails++;
         $display("[TB] FAIL lfsr_free_run: got %h, required %h", rand_idx, m_lfsr[5:0]);
      end
   endtask

   task automatic test_enable_stall();
      logic [63:0] field;
      logic [5:0]  r;
      int          changed;
      enable = 1'b1;
      pulse_start();
      for (int i = 0; i < 4; i++) tick();
      enable  = 1'b0;
      tick();
      field   = m_mine;
      r       = m_lfsr[5:0];
      changed = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (mine !== field || rand_idx !== r || gen_done !== 1'b0) changed++;
      end
      n_checks++;
      if (changed != 0) begin
         n_fails++;
         $display("[TB] FAIL stall_hold: %0d cycles differed, mine=%h rand=%h", changed, mine, rand_idx);
      end
      n_checks++;
      if ($countones(mine) != 4) begin
         n_fails++;
         $display("[TB] FAIL stall_popcount: got %0d, required 4", $countones(mine));
      end
      enable = 1'b1;
      run_to_done("stall_resume");
   endtask

   task automatic test_restart();
      for (int i = 0; i < 5; i++) tick();
      pulse_start();
      for (int i = 0; i < 5; i++) tick();
      pulse_start();
      n_checks++;
      if (mine !== 64'h0 || gen_done !== 1'b0) begin
         n_fails++;
         $display("[TB] FAIL restart_gen: mine=%h gen_done=%b, required 0/0", mine, gen_done);
      end
      run_to_done("restart_gen");
      pulse_start();
      n_checks++;
      if (mine !== 64'h0 || gen_done !== 1'b0) begin
         n_fails++;
         $display("[TB] FAIL restart_done: mine=%h gen_done=%b, required 0/0", mine, gen_done);
      end
      run_to_done("restart_done");
   endtask

   task automatic test_async_reset();
      pulse_start();
      tick();
      tick();
      tick();
      #2;
      n_reset = 1'b0;
      #1;
      n_checks++;
      if (mine !== 64'h0 || gen_done !== 1'b0 || rand_idx !== 6'h21) begin
         n_fails++;
         $display("[TB] FAIL async_reset: mine=%h gen_done=%b rand=%h, required 0/0/21", mine, gen_done, rand_idx);
      end
      tick();
      n_reset = 1'b1;
      tick();
      tick();
      n_checks++;
      if (mine !== 64'h0 || gen_done !== 1'b0 || rand_idx !== 6'h07) begin
         n_fails++;
         $display("[TB] FAIL no_resume: mine=%h gen_done=%b rand=%h, required 0/0/07", mine, gen_done, rand_idx);
      end
   endtask

   initial begin
      n_checks = 0;
      n_fails  = 0;
      n_reset  = 1'b0;
      enable   = 1'b0;
      start    = 1'b0;
      test_reset();
      test_first_placements();
      test_free_run();
      test_enable_stall();
      test_restart();
      test_async_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
